// File: rtl/midi_pkg.sv
// Shared MIDI definitions: status nibbles, line timing and message sizing.
// Used by both the transmit and receive paths.
package midi_pkg;

   localparam logic [3:0] NOTE_OFF   = 4'h8;
   localparam logic [3:0] NOTE_ON    = 4'h9;
   localparam logic [3:0] CTRL       = 4'hB;
   localparam logic [3:0] PROG       = 4'hC;
   localparam logic [3:0] CHAN_PRESS = 4'hD;
   localparam logic [3:0] PITCH      = 4'hE;
   localparam logic [3:0] SYS        = 4'hF;

   // Status bytes always have bit 7 set, so zero encodes "no running status".
   localparam logic [7:0] RS_NONE = 8'h00;

   typedef enum logic [1:0] {
      IDLE,
      START,
      DATA,
      STOP
   } tx_state_t;

   function automatic int clks_per_bit(input int clock_hz, input int baud);
      return clock_hz / baud;
   endfunction

   localparam int DEF_CLOCK_HZ     = 50_000_000;
   localparam int DEF_BAUD         = 31250;
   localparam int DEF_CLKS_PER_BIT = clks_per_bit(DEF_CLOCK_HZ, DEF_BAUD);

   function automatic logic [1:0] byte_count(input logic [7:0] status);
      logic [1:0] n;
      unique case (status[7:4])
         PROG, CHAN_PRESS: n = 2'd2;
         SYS:              n = 2'd1;
         default:          n = 2'd3;
      endcase
      return n;
   endfunction

   function automatic logic is_channel(input logic [7:0] status);
      return status[7] && (status[7:4] != SYS);
   endfunction

endpackage

// File: rtl/midi_uart_tx.sv
// Single-byte 8N1 serializer; a byte offered during the last stop-bit cycle
// is loaded so its start bit follows with no idle gap.
module midi_uart_tx
   import midi_pkg::*;
#(
   parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       byte_valid,
   input  logic [7:0] byte_data,
   output logic       byte_ready,
   output logic       tx,
   output logic       busy
);

   localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

   tx_state_t  state;
   tx_state_t  state_next;
   logic [CW-1:0] cnt;
   logic [2:0] bit_idx;
   logic [7:0] shreg;
   logic       line;
   logic       line_next;
   logic       bit_end;
   logic       load;

   assign bit_end    = (cnt == LAST);
   assign byte_ready = (state == IDLE) || (state == STOP && bit_end);
   assign load       = byte_valid && byte_ready;

   always_ff @(posedge clk) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_next;
   end

   always_comb begin
      state_next = state;
      unique case (state)
         IDLE:  if (load) state_next = START;
         START: if (bit_end) state_next = DATA;
         DATA:  if (bit_end && bit_idx == 3'd7) state_next = STOP;
         STOP:  if (bit_end) state_next = load ? START : IDLE;
      endcase
   end

   // Next line level; the line register changes only at bit boundaries.
   always_comb begin
      line_next = line;
      if (load) begin
         line_next = 1'b0;
      end else if (bit_end) begin
         unique case (state)
            IDLE:  line_next = line;
            START: line_next = shreg[0];
            DATA:  line_next = (bit_idx == 3'd7) ? 1'b1 : shreg[1];
            STOP:  line_next = 1'b1;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt     <= '0;
         bit_idx <= 3'd0;
         shreg   <= 8'h00;
         line    <= 1'b1;
      end else begin
         line <= line_next;
         if (load || state == IDLE || bit_end) cnt <= '0;
         else                                  cnt <= cnt + CW'(1);
         if (load) begin
            shreg   <= byte_data;
            bit_idx <= 3'd0;
         end else if (state == DATA && bit_end) begin
            shreg   <= shreg >> 1;
            bit_idx <= bit_idx + 3'd1;
         end
      end
   end

   assign tx   = line;
   assign busy = (state != IDLE);

endmodule

// File: rtl/midi_transmitter.sv
// MIDI OUT message sequencer: sizes each message, applies running status
// and feeds its bytes back-to-back into the 8N1 serializer.
module midi_transmitter
   import midi_pkg::*;
#(
   parameter int CLOCK_HZ       = 50_000_000,
   parameter int BAUD           = 31250,
   parameter int RUNNING_STATUS = 1
) (
   input  logic       CLOCK_50,
   input  logic       RESET_N,
   input  logic       msg_valid,
   output logic       msg_ready,
   input  logic [7:0] msg_status,
   input  logic [6:0] msg_data1,
   input  logic [6:0] msg_data2,
   output logic       msg_error,
   output logic       MIDI_TX,
   output logic       busy
);

   localparam int CLKS = clks_per_bit(CLOCK_HZ, BAUD);

   logic       accept;
   logic       good;
   logic       chan;
   logic       skip;
   logic [7:0] running;
   logic [1:0] pend_cnt;
   logic [7:0] pend0;
   logic [7:0] pend1;
   logic       byte_valid;
   logic       byte_ready;
   logic [7:0] byte_data;
   logic       uart_busy;
   logic       error;

   assign accept = msg_valid && msg_ready;
   assign good   = accept && msg_status[7];
   assign chan   = is_channel(msg_status);
   assign skip   = (RUNNING_STATUS != 0) && chan
                && (msg_status == running);

   assign msg_ready = !uart_busy && (pend_cnt == 2'd0);

   // The first byte goes straight to the serializer on the accept edge.
   assign byte_valid = msg_ready ? good : (pend_cnt != 2'd0);
   assign byte_data  = !msg_ready ? pend0
                     : skip       ? {1'b0, msg_data1}
                     :              msg_status;

   always_ff @(posedge CLOCK_50) begin
      if (!RESET_N) begin
         running  <= RS_NONE;
         pend_cnt <= 2'd0;
         pend0    <= 8'h00;
         pend1    <= 8'h00;
         error    <= 1'b0;
      end else begin
         error <= accept && !msg_status[7];
         if (good) begin
            // Real-time statuses (F8-FF) leave running status alone.
            if (chan)                running <= msg_status;
            else if (!msg_status[3]) running <= RS_NONE;
            pend_cnt <= byte_count(msg_status) - 2'd1 - {1'b0, skip};
            pend0    <= skip ? {1'b0, msg_data2} : {1'b0, msg_data1};
            pend1    <= {1'b0, msg_data2};
         end else if (byte_valid && byte_ready) begin
            pend0    <= pend1;
            pend_cnt <= pend_cnt - 2'd1;
         end
      end
   end

   midi_uart_tx #(
      .CLKS_PER_BIT(CLKS)
   ) u_uart (
      .clk       (CLOCK_50),
      .rst_n     (RESET_N),
      .byte_valid(byte_valid),
      .byte_data (byte_data),
      .byte_ready(byte_ready),
      .tx        (MIDI_TX),
      .busy      (uart_busy)
   );

   assign msg_error = error;
   assign busy      = uart_busy;

endmodule

// File: tb/tb_midi_transmitter.sv
// Scoreboard bench: two transmitters (running status on/off) with a
// line-decoding monitor that checks every frame against expected bytes.
module tb_midi_transmitter;

   localparam int CPB    = 20;
   localparam int CLK_HZ = 31250 * CPB;
   localparam int HALF   = CPB / 2;

   typedef struct packed {
      logic       m;
      logic [7:0] b;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [7:0] status;
   logic [6:0] d1;
   logic [6:0] d2;
   logic [1:0] vld;
   logic [1:0] rdy;
   logic [1:0] err;
   logic [1:0] tx;
   logic [1:0] bsy;

   exp_t       expq[$];
   int         checks = 0;
   int         errors = 0;

   always #5 clk = ~clk;

   midi_transmitter #(
      .CLOCK_HZ(CLK_HZ), .BAUD(31250), .RUNNING_STATUS(1)
   ) dut_rs (
      .CLOCK_50(clk), .RESET_N(rst_n),
      .msg_valid(vld[0]), .msg_ready(rdy[0]),
      .msg_status(status), .msg_data1(d1), .msg_data2(d2),
      .msg_error(err[0]), .MIDI_TX(tx[0]), .busy(bsy[0])
   );

   midi_transmitter #(
      .CLOCK_HZ(CLK_HZ), .BAUD(31250), .RUNNING_STATUS(0)
   ) dut_nrs (
      .CLOCK_50(clk), .RESET_N(rst_n),
      .msg_valid(vld[1]), .msg_ready(rdy[1]),
      .msg_status(status), .msg_data1(d1), .msg_data2(d2),
      .msg_error(err[1]), .MIDI_TX(tx[1]), .busy(bsy[1])
   );

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h at %0t",
                  name, act, exp, $time);
      end
   endtask

   // Frame decoder: samples the centre of every bit at the falling edge.
   bit         act[2];
   int         t[2];
   logic [7:0] sh[2];
   always @(negedge clk) begin
      for (int m = 0; m < 2; m++) begin
         if (!rst_n) act[m] = 1'b0;
         else if (!act[m]) begin
            if (tx[m] == 1'b0) begin
               act[m] = 1'b1;
               t[m]   = 0;
            end
         end else t[m]++;
         if (act[m] && t[m] >= HALF && (t[m] - HALF) % CPB == 0) begin
            int k;
            k = (t[m] - HALF) / CPB;
            if (k == 0) chk("start_bit", 32'(tx[m]), 0);
            else if (k <= 8) sh[m][k-1] = tx[m];
            else begin
               exp_t e;
               chk("stop_bit", 32'(tx[m]), 1);
               if (expq.size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL unexpected_frame: dut %0d got %0h, expected none",
                           m, sh[m]);
               end else begin
                  e = expq.pop_front();
                  chk("frame_dut", m, 32'(e.m));
                  chk("frame_byte", 32'(sh[m]), 32'(e.b));
               end
               act[m] = 1'b0;
            end
         end
      end
   end

   task automatic push(input bit m, input logic [7:0] b);
      expq.push_back({m, b});
   endtask

   task automatic send(input int m, input logic [7:0] st,
                       input logic [6:0] a, input logic [6:0] b,
                       input int nbytes);
      int cyc;
      cyc = 0;
      chk("ready_before_send", 32'(rdy[m]), 1);
      status = st;
      d1     = a;
      d2     = b;
      vld[m] = 1'b1;
      @(posedge clk);
      #1 vld[m] = 1'b0;
      @(negedge clk);
      chk("msg_error", 32'(err[m]), st[7] ? 0 : 1);
      while (!rdy[m] && cyc < 4 * 10 * CPB) begin
         chk("busy_while_sending", 32'(bsy[m]), 1);
         cyc++;
         @(negedge clk);
      end
      chk("duration", cyc, nbytes * 10 * CPB);
      @(negedge clk);
      chk("error_cleared", 32'(err[m]), 0);
      chk("line_idle", 32'(tx[m]), 1);
   endtask

   initial begin
      rst_n  = 1'b0;
      vld    = 2'b00;
      status = 8'h00;
      d1     = 7'h00;
      d2     = 7'h00;
      repeat (3) @(posedge clk);
      #1;
      for (int m = 0; m < 2; m++) begin
         chk("reset_tx", 32'(tx[m]), 1);
         chk("reset_ready", 32'(rdy[m]), 1);
         chk("reset_busy", 32'(bsy[m]), 0);
         chk("reset_error", 32'(err[m]), 0);
      end
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      push(0, 8'h90); push(0, 8'h3C); push(0, 8'h64);
      send(0, 8'h90, 7'h3C, 7'h64, 3);
      push(0, 8'h40); push(0, 8'h00);
      send(0, 8'h90, 7'h40, 7'h00, 2);

      push(1, 8'h90); push(1, 8'h3C); push(1, 8'h64);
      send(1, 8'h90, 7'h3C, 7'h64, 3);
      push(1, 8'h90); push(1, 8'h40); push(1, 8'h00);
      send(1, 8'h90, 7'h40, 7'h00, 3);

      push(0, 8'hC5); push(0, 8'h07);
      send(0, 8'hC5, 7'h07, 7'h00, 2);
      push(0, 8'hF8);
      send(0, 8'hF8, 7'h11, 7'h22, 1);
      push(0, 8'h08);
      send(0, 8'hC5, 7'h08, 7'h00, 1);

      push(0, 8'h90); push(0, 8'h3C); push(0, 8'h64);
      send(0, 8'h90, 7'h3C, 7'h64, 3);
      push(0, 8'hF0);
      send(0, 8'hF0, 7'h00, 7'h00, 1);
      push(0, 8'h90); push(0, 8'h3C); push(0, 8'h64);
      send(0, 8'h90, 7'h3C, 7'h64, 3);

      send(0, 8'h3C, 7'h01, 7'h02, 0);

      // Abandon a Note On part-way through its status byte.
      status = 8'h90;
      d1     = 7'h3C;
      d2     = 7'h64;
      vld[0] = 1'b1;
      @(posedge clk);
      #1 vld[0] = 1'b0;
      repeat (63) @(negedge clk);
      chk("midframe_busy", 32'(bsy[0]), 1);
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      chk("midreset_tx", 32'(tx[0]), 1);
      chk("midreset_busy", 32'(bsy[0]), 0);
      chk("midreset_ready", 32'(rdy[0]), 1);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      push(0, 8'h90); push(0, 8'h40); push(0, 8'h00);
      send(0, 8'h90, 7'h40, 7'h00, 3);

      repeat (2 * CPB) @(negedge clk);
      chk("queue_drained", expq.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/midi_transmitter.md
# midi_transmitter

Serializes MIDI channel and system messages onto a 31250-baud, 8N1 MIDI OUT line. It is the transmit-side counterpart of the existing MIDI receive path and sits beside the synthesizer top level. A local note source, such as keys or a sequencer, offers one complete message per valid/ready handshake. The block derives the byte count from the status byte, optionally applies running status, and shifts the bytes out LSB-first.

## Interface
- CLOCK_HZ, 50_000_000: system clock frequency.
- BAUD, 31250: MIDI bit rate. CLKS_PER_BIT = CLOCK_HZ/BAUD = 1600; the quotient must be exact.
- RUNNING_STATUS, 1: 1 omits a repeated channel status byte; 0 always sends the status byte.
- CLOCK_50  in  1  system clock; all logic on the rising edge.
- RESET_N  in  1  synchronous, active-low reset.
- msg_valid  in  1  a message is offered.
- msg_ready  out  1  the block can accept a message.
- msg_status  in  8  status byte; bit 7 must be 1.
- msg_data1  in  7  first data byte.
- msg_data2  in  7  second data byte.
- msg_error  out  1  one-cycle pulse when an offered message is rejected.
- MIDI_TX  out  1  serial line; idles high.
- busy  out  1  high while a frame is on the line.

## Operation
- Reset values:
  - MIDI_TX=1, msg_ready=1, busy=0, msg_error=0.
  - Running-status register cleared to "none".
  - FSM in IDLE.
- Handshake:
  - A message is accepted on a cycle with msg_valid & msg_ready.
  - All message inputs are captured on that edge.
  - msg_ready is high only in IDLE.
- Rejection: an accepted message with msg_status[7]=0 is dropped.
  - msg_error pulses for the following cycle.
  - Nothing is transmitted; the FSM stays in IDLE.
- Byte count by status[7:4]:
  - 8,9,A,B,E: 3 bytes.
  - C,D: 2 bytes.
  - F: 1 byte (status only); data inputs are ignored.
- Running status applies only when RUNNING_STATUS=1 and the status is in 0x80–0xEF.
  - If the status equals the stored running status, the status byte is skipped.
  - Otherwise the status byte is sent and stored.
- Effect of system statuses on running status:
  - 0xF0–0xF7 clear running status to "none".
  - 0xF8–0xFF (real-time) leave it unchanged.
- FSM states and transitions:
  - IDLE → START on accept.
  - START → DATA after 1 bit time.
  - DATA → STOP after 8 bit times.
  - STOP → START if more bytes remain; otherwise STOP → IDLE.
- Line levels and bit order:
  - START drives 0 and STOP drives 1.
  - DATA shifts bits 0..7 LSB-first.
  - Data bytes are sent as {1'b0, data[6:0]}.
- busy is high in START, DATA and STOP.

## Timing
- Each bit lasts exactly CLKS_PER_BIT cycles, timed by a counter that reloads at every bit boundary. No cumulative drift is allowed.
- Start-bit timing:
  - The first start bit appears on MIDI_TX the cycle after the accept edge.
  - MIDI_TX is registered with no combinational path from the inputs.
- Consecutive bytes of one message go back-to-back: the next start bit immediately follows a 1-bit-time stop bit.
- Message length on the line: N bytes occupy exactly N*10*CLKS_PER_BIT cycles.
  - msg_ready rises on the first cycle after the final stop bit completes.
  - A new message accepted on that same cycle starts its start bit one cycle later.
- msg_valid held high through busy has no effect; no second message is queued.
- Reset asserted mid-frame:
  - On the next edge MIDI_TX=1 and all outputs take their reset values.
  - The partial frame is abandoned and running status is cleared.

## Structure
- Shared package midi_pkg holds:
  - Status-nibble constants (NOTE_OFF=4'h8, NOTE_ON=4'h9, CTRL=4'hB, PROG=4'hC, CHAN_PRESS=4'hD, PITCH=4'hE, SYS=4'hF).
  - A byte-count function of the status byte.
  - The CLKS_PER_BIT localparam derivation.
- The receiver reuses the same package.
- Sub-module midi_uart_tx: single-byte 8N1 serializer with a byte_valid/byte_ready handshake and its own bit counter.
- midi_transmitter is the message sequencer and running-status logic around midi_uart_tx.

## Test plan
- Note On, status 0x90, data 0x3C, 0x64, after reset:
  - Decoded line is 0x90, 0x3C, 0x64, each start bit low for 1600 cycles.
  - Total duration 48000 cycles; msg_ready is low throughout.
- Running status: second message 0x90 0x40 0x00 with RUNNING_STATUS=1.
  - Only 0x40, 0x00 are sent (32000 cycles).
  - Same message with RUNNING_STATUS=0 sends 3 bytes.
- Program Change, status 0xC5, data 0x07:
  - 2 bytes, 0xC5 then 0x07, 32000 cycles.
  - A following 0xF8 sends 1 byte and keeps running status 0xC5; a following 0xC5 0x08 sends only 0x08.
- Running-status clear: 0x90 message, then 0xF0, then 0x90 message.
  - The third message sends its status byte again.
- Invalid status 0x3C offered:
  - msg_error pulses once; MIDI_TX stays high; msg_ready stays 1.
- Reset mid-frame: RESET_N low at cycle 5000 of a Note On.
  - Next cycle MIDI_TX=1, busy=0, msg_ready=1.
  - A subsequent 0x90 message sends its status byte.
